// File: rtl/encoder_sequencer_if.sv
// Handshake and engine-control bundle between the encoder sequencer and the
// encoder datapath / top level. The sequencer drives through the master modport.
interface encoder_sequencer_if;
  // top-level request/status
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] state_dbg;
  // engine strobes and busy flags
  logic       mult_in_start;
  logic [3:0] mult_in_busy;
  logic       bias_load;
  logic       softplus_start;
  logic       sqrt_start;
  logic [1:0] sqrt_busy;
  logic       mult_out_start;
  logic [1:0] mult_out_busy;
  logic       out_load;

  modport master (
    input  start, mult_in_busy, sqrt_busy, mult_out_busy,
    output busy, done, err, state_dbg,
           mult_in_start, bias_load, softplus_start, sqrt_start,
           mult_out_start, out_load
  );

  modport slave (
    output start, mult_in_busy, sqrt_busy, mult_out_busy,
    input  busy, done, err, state_dbg,
           mult_in_start, bias_load, softplus_start, sqrt_start,
           mult_out_start, out_load
  );
endinterface

// File: rtl/encoder_sequencer.sv
// Control FSM for one encoder pass: input multiply, bias latch, softplus,
// sqrt, output multiply, output latch. Moore-decoded strobes, shared
// per-state counter for the softplus delay and the wait-state watchdog.
module encoder_sequencer #(
  parameter int unsigned SOFTPLUS_CYCLES = 2,   // 1..15
  parameter int unsigned BUSY_SETTLE     = 1,   // 1..15
  parameter int unsigned TIMEOUT         = 255  // 2..255
) (
  input logic                  clk,
  input logic                  rst,
  encoder_sequencer_if.master  sq
);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_MUL_IN       = 4'd1,
    S_WAIT_MUL     = 4'd2,
    S_BIAS         = 4'd3,
    S_SOFTPLUS     = 4'd4,
    S_SQRT         = 4'd5,
    S_WAIT_SQRT    = 4'd6,
    S_MUL_OUT      = 4'd7,
    S_WAIT_MUL_OUT = 4'd8,
    S_OUT          = 4'd9,
    S_ERR          = 4'd10
  } state_e;

  localparam logic [7:0] SP_LAST = 8'(SOFTPLUS_CYCLES - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [8:0] SETTLE  = 9'(BUSY_SETTLE);

  state_e     state_q, state_d;
  logic [7:0] cnt_q;
  logic       err_q;
  logic       wait_busy;
  logic       settled;
  logic       release_ok;
  logic       timed_out;

  // Busy flags that gate the exit of the current wait state (0 elsewhere).
  always_comb begin
    wait_busy = 1'b0;
    case (state_q)
      S_WAIT_MUL:     wait_busy = |sq.mult_in_busy;
      S_WAIT_SQRT:    wait_busy = |sq.sqrt_busy;
      S_WAIT_MUL_OUT: wait_busy = |sq.mult_out_busy;
      default:        wait_busy = 1'b0;
    endcase
  end

  // cnt >= BUSY_SETTLE-1, written as cnt+1 >= BUSY_SETTLE to stay clear of
  // a constant compare against zero when BUSY_SETTLE is 1.
  assign settled    = ({1'b0, cnt_q} + 9'd1) >= SETTLE;
  // Normal exit is tested first so a busy drop on the last allowed cycle wins.
  assign release_ok = settled && !wait_busy;
  assign timed_out  = (cnt_q == TO_LAST) && wait_busy;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (sq.start) state_d = S_MUL_IN;
      S_MUL_IN:       state_d = S_WAIT_MUL;
      S_WAIT_MUL: begin
        if (release_ok)     state_d = S_BIAS;
        else if (timed_out) state_d = S_ERR;
      end
      S_BIAS:         state_d = S_SOFTPLUS;
      S_SOFTPLUS:     if (cnt_q == SP_LAST) state_d = S_SQRT;
      S_SQRT:         state_d = S_WAIT_SQRT;
      S_WAIT_SQRT: begin
        if (release_ok)     state_d = S_MUL_OUT;
        else if (timed_out) state_d = S_ERR;
      end
      S_MUL_OUT:      state_d = S_WAIT_MUL_OUT;
      S_WAIT_MUL_OUT: begin
        if (release_ok)     state_d = S_OUT;
        else if (timed_out) state_d = S_ERR;
      end
      S_OUT:          state_d = S_IDLE;
      S_ERR:          state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Per-state cycle counter: zero on every state change and while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        cnt_q <= 8'd0;
    else if (state_d != state_q || state_q == S_IDLE) cnt_q <= 8'd0;
    else                                            cnt_q <= cnt_q + 8'd1;
  end

  // Sticky error: set on entry to ERR, cleared when a new pass is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_q <= 1'b0;
    else if (state_d == S_ERR)             err_q <= 1'b1;
    else if (state_q == S_IDLE && sq.start) err_q <= 1'b0;
  end

  // Moore output decode; every strobe is tied to its own state.
  always_comb begin
    sq.mult_in_start  = 1'b0;
    sq.bias_load      = 1'b0;
    sq.softplus_start = 1'b0;
    sq.sqrt_start     = 1'b0;
    sq.mult_out_start = 1'b0;
    sq.out_load       = 1'b0;
    sq.done           = 1'b0;
    case (state_q)
      S_MUL_IN:   sq.mult_in_start  = 1'b1;
      S_BIAS:     sq.bias_load      = 1'b1;
      S_SOFTPLUS: sq.softplus_start = (cnt_q == 8'd0);
      S_SQRT:     sq.sqrt_start     = 1'b1;
      S_MUL_OUT:  sq.mult_out_start = 1'b1;
      S_OUT: begin
        sq.out_load = 1'b1;
        sq.done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign sq.busy      = (state_q != S_IDLE);
  assign sq.err       = err_q;
  assign sq.state_dbg = state_q;

endmodule

// File: tb/tb_encoder_sequencer.sv
// Bench for encoder_sequencer: two instances with different parameters share
// one stimulus timeline (directed scenarios, then random). A pass-level
// reference model builds the expected per-cycle trace up front.
`timescale 1ns/1ps
module tb_encoder_sequencer;
  localparam int NC  = 2000;
  localparam int NA  = NC + 400;
  localparam int SP0 = 2, BS0 = 1, TO0 = 8;
  localparam int SP1 = 3, BS1 = 3, TO1 = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encoder_sequencer_if if0();
  encoder_sequencer_if if1();

  encoder_sequencer #(.SOFTPLUS_CYCLES(SP0), .BUSY_SETTLE(BS0), .TIMEOUT(TO0))
    u_dut0 (.clk(clk), .rst(rst), .sq(if0));
  encoder_sequencer #(.SOFTPLUS_CYCLES(SP1), .BUSY_SETTLE(BS1), .TIMEOUT(TO1))
    u_dut1 (.clk(clk), .rst(rst), .sq(if1));

  logic [12:0] o0, o1;
  assign o0 = {if0.state_dbg, if0.busy, if0.done, if0.err, if0.mult_in_start, if0.bias_load,
               if0.softplus_start, if0.sqrt_start, if0.mult_out_start, if0.out_load};
  assign o1 = {if1.state_dbg, if1.busy, if1.done, if1.err, if1.mult_in_start, if1.bias_load,
               if1.softplus_start, if1.sqrt_start, if1.mult_out_start, if1.out_load};

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus timeline, one entry per cycle
  bit         start_v [NA];
  bit         rst_v   [NA];
  logic [3:0] mib_v   [NA];
  logic [1:0] sqb_v   [NA];
  logic [1:0] mob_v   [NA];

  // expected trace per instance
  int x_st  [2][NA];
  bit x_err [2][NA];
  bit x_sp  [2][NA];

  task automatic build_stim();
    int h0, h1, h2;
    logic [3:0] v0;
    logic [1:0] v1, v2;
    h0 = 0; h1 = 0; h2 = 0; v0 = '0; v1 = '0; v2 = '0;
    for (int c = 0; c < NA; c++) begin
      start_v[c] = 0; rst_v[c] = 0; mib_v[c] = '0; sqb_v[c] = '0; mob_v[c] = '0;
    end
    start_v[2] = 1;                                       // minimum-latency pass
    start_v[15] = 1;                                      // stretched WAIT_MUL
    for (int c = 16; c <= 20; c++) mib_v[c] = 4'b0100;
    start_v[31] = 1;                                      // sqrt timeout
    for (int c = 37; c <= 47; c++) sqb_v[c] = 2'b10;
    start_v[52] = 1;                                      // recovery pass
    for (int c = 64; c <= 90; c++) start_v[c] = 1;        // start held high
    start_v[100] = 1; rst_v[104] = 1;                     // reset in SOFTPLUS
    start_v[110] = 1;                                     // drop at last cycle
    for (int c = 116; c <= 123; c++) sqb_v[c] = 2'b01;
    for (int c = 130; c < NC; c++) begin
      start_v[c] = ($urandom_range(0, 2) == 0);
      rst_v[c]   = ($urandom_range(0, 199) == 0);
      if (h0 == 0) begin h0 = $urandom_range(1, 12); v0 = $urandom_range(0, 1) ? 4'($urandom) : 4'd0; end
      if (h1 == 0) begin h1 = $urandom_range(1, 12); v1 = $urandom_range(0, 1) ? 2'($urandom) : 2'd0; end
      if (h2 == 0) begin h2 = $urandom_range(1, 12); v2 = $urandom_range(0, 1) ? 2'($urandom) : 2'd0; end
      h0--; h1--; h2--;
      mib_v[c] = v0; sqb_v[c] = v1; mob_v[c] = v2;
    end
  endtask

  // ---- reference model: walks each pass as a list of phases ----
  int p;
  bit ab, tmo, err_m;

  function automatic bit busy_of(input int g, input int k);
    case (g)
      0:       return mib_v[k] != 0;
      1:       return sqb_v[k] != 0;
      default: return mob_v[k] != 0;
    endcase
  endfunction

  // record one cycle; a reset inside the cycle zeroes outputs and aborts
  task automatic put(input int k, input int st, input bit spf);
    if (rst_v[p]) begin
      x_st[k][p] = 0; x_err[k][p] = 0; x_sp[k][p] = 0; err_m = 0; ab = 1;
    end else begin
      x_st[k][p] = st; x_err[k][p] = err_m; x_sp[k][p] = spf;
    end
    p++;
  endtask

  task automatic wait_seg(input int k, input int st, input int g, input int bs, input int to);
    int n;
    bit b;
    n = 0; tmo = 0;
    forever begin
      b = busy_of(g, p);
      put(k, st, 0);
      if (ab) return;
      if (n >= bs - 1 && !b) return;
      if (n == to - 1 && b) begin tmo = 1; return; end
      n++;
    end
  endtask

  task automatic do_err(input int k);
    err_m = 1;
    put(k, 10, 0);
  endtask

  task automatic pass(input int k, input int sp, input int bs, input int to);
    put(k, 1, 0); if (ab) return;
    wait_seg(k, 2, 0, bs, to); if (ab) return;
    if (tmo) begin do_err(k); return; end
    put(k, 3, 0); if (ab) return;
    for (int i = 0; i < sp; i++) begin put(k, 4, i == 0); if (ab) return; end
    put(k, 5, 0); if (ab) return;
    wait_seg(k, 6, 1, bs, to); if (ab) return;
    if (tmo) begin do_err(k); return; end
    put(k, 7, 0); if (ab) return;
    wait_seg(k, 8, 2, bs, to); if (ab) return;
    if (tmo) begin do_err(k); return; end
    put(k, 9, 0);
  endtask

  task automatic run_model(input int k, input int sp, input int bs, input int to);
    bit acc;
    p = 0; err_m = 0;
    while (p < NC) begin
      ab = 0;
      acc = start_v[p] && !rst_v[p];
      put(k, 0, 0);
      if (acc) begin
        err_m = 0;
        pass(k, sp, bs, to);
      end
    end
  endtask

  function automatic logic [12:0] expv(input int k, input int c);
    logic [3:0] s;
    s = 4'(x_st[k][c]);
    return {s, s != 0, s == 9, x_err[k][c], s == 1, s == 3, x_sp[k][c], s == 5, s == 7, s == 9};
  endfunction

  // ---- directed spot checks on instance 0 against hand-derived values ----
  int sp_cnt = 0, done_cnt = 0;
  int seq_min [11] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 0};

  task automatic dir_chk(input int c);
    if (c >= 3 && c <= 13) chk($sformatf("min_seq_c%0d", c), 32'(if0.state_dbg), seq_min[c - 3]);
    if (c >= 105 && c <= 109) chk($sformatf("post_rst_c%0d", c), 32'(o0), 0);
    case (c)
      1:   chk("idle_pre",     32'(if0.state_dbg), 0);
      12:  chk("min_done",     32'(if0.done), 1);
      13:  chk("sp_once",      32'(sp_cnt), 1);
      21:  chk("busy_hold",    32'(if0.state_dbg), 2);
      22:  chk("bias_after",   32'(if0.bias_load), 1);
      29:  chk("done_shift4",  32'(if0.done), 1);
      45:  chk("tmo_last",     32'(if0.state_dbg), 6);
      46: begin
        chk("tmo_err_st",      32'(if0.state_dbg), 10);
        chk("tmo_err_flag",    32'(if0.err), 1);
      end
      47:  chk("tmo_idle",     32'(if0.state_dbg), 0);
      51:  chk("err_sticky",   32'(if0.err), 1);
      53:  chk("err_cleared",  32'(if0.err), 0);
      62:  chk("recov_done",   32'(if0.done), 1);
      74:  chk("b2b_done1",    32'(if0.done), 1);
      85:  chk("b2b_done2",    32'(if0.done), 1);
      96:  chk("b2b_done3",    32'(if0.done), 1);
      100: chk("b2b_count",    32'(done_cnt), 3);
      103: chk("pre_rst_bias", 32'(if0.state_dbg), 3);
      104: chk("async_rst",    32'(o0), 0);
      124: chk("edge_wait",    32'(if0.state_dbg), 6);
      125: chk("edge_exit",    32'(if0.state_dbg), 7);
      127: begin
        chk("edge_done",       32'(if0.done), 1);
        chk("edge_no_err",     32'(if0.err), 0);
      end
      default: ;
    endcase
  endtask

  task automatic drive(input int c);
    if0.start = start_v[c];  if1.start = start_v[c];
    if0.mult_in_busy = mib_v[c];  if1.mult_in_busy = mib_v[c];
    if0.sqrt_busy = sqb_v[c];     if1.sqrt_busy = sqb_v[c];
    if0.mult_out_busy = mob_v[c]; if1.mult_out_busy = mob_v[c];
  endtask

  initial begin
    build_stim();
    run_model(0, SP0, BS0, TO0);
    run_model(1, SP1, BS1, TO1);
    if0.start = 0; if0.mult_in_busy = '0; if0.sqrt_busy = '0; if0.mult_out_busy = '0;
    if1.start = 0; if1.mult_in_busy = '0; if1.sqrt_busy = '0; if1.mult_out_busy = '0;
    #2;
    chk("reset_outs0", 32'(o0), 0);
    chk("reset_outs1", 32'(o1), 0);
    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(c);
      #2;
      if (rst_v[c]) rst = 1'b1;
      @(negedge clk);
      chk($sformatf("trace0_c%0d", c), 32'(o0), 32'(expv(0, c)));
      chk($sformatf("trace1_c%0d", c), 32'(o1), 32'(expv(1, c)));
      if (c >= 3 && c <= 13) sp_cnt += int'(if0.softplus_start);
      if (c >= 64 && c <= 100) done_cnt += int'(if0.done);
      dir_chk(c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
